// File: rtl/spike_generator_bank_pkg.sv
// Shared widths, generator entry type and program-FSM states for the spike generator bank.
package spike_gen_pkg;

    localparam int NGENS   = 8;
    localparam int NIDX    = $clog2(NGENS);
    localparam int NPERIOD = 16;
    localparam int NTAG    = 11;
    localparam int NCT     = 10;

    typedef struct packed {
        logic [NPERIOD-1:0] period;
        logic [NPERIOD-1:0] cnt;
        logic [NTAG-1:0]    tag;
        logic [NCT-1:0]     ct;
    } gen_entry_t;

    typedef gen_entry_t [NGENS-1:0] gen_array_t;

    typedef enum logic {
        PROG_IDLE,
        PROG_ACK
    } prog_state_e;

    // Generator index successor, wrapping NGENS-1 back to 0.
    function automatic logic [NIDX-1:0] nextIdx(input logic [NIDX-1:0] idx);
        if (int'(idx) == NGENS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/spike_generator_bank_if.sv
// Program channel (valid/ack) and spike output channel (valid/ready) of the spike generator bank.
interface spike_generator_bank_if;
    import spike_gen_pkg::*;

    logic [NIDX-1:0]    prog_gen_idx;
    logic [NPERIOD-1:0] prog_period;
    logic [NPERIOD-1:0] prog_ticks;
    logic [NTAG-1:0]    prog_tag;
    logic [NCT-1:0]     prog_ct;
    logic               prog_v;
    logic               prog_a;

    logic [NTAG-1:0]    out_tag;
    logic [NCT-1:0]     out_ct;
    logic               out_v;
    logic               out_r;

    // The bank side: accepts programming, produces spikes.
    modport master (
        input  prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_ct, prog_v,
        output prog_a,
        output out_tag, out_ct, out_v,
        input  out_r
    );

    modport slave (
        output prog_gen_idx, prog_period, prog_ticks, prog_tag, prog_ct, prog_v,
        input  prog_a,
        input  out_tag, out_ct, out_v,
        output out_r
    );

endinterface

// File: rtl/spike_generator_bank_rr_pending_arbiter.sv
// Round-robin pick of the first pending generator at or after the pointer, wrapping to 0.
module rr_pending_arbiter
    import spike_gen_pkg::*;
(
    input  logic [NGENS-1:0] pending_i,
    input  logic [NIDX-1:0]  ptr_i,
    output logic [NIDX-1:0]  grant_o,
    output logic             any_o
);

    logic [NIDX-1:0] scanIdx;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        scanIdx = ptr_i;
        for (int k = 0; k < NGENS; k++) begin
            if (!any_o && pending_i[scanIdx]) begin
                grant_o = scanIdx;
                any_o   = 1'b1;
            end
            scanIdx = nextIdx(scanIdx);
        end
    end

endmodule

// File: rtl/spike_generator_bank.sv
// Bank of periodic spike generators merged round-robin onto one spike channel.
// Optional SPIKE_GEN_OVERFLOW_CNT_EN adds a saturating ovf_count of dropped fires.
module spike_generator_bank
    import spike_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic time_unit,
    spike_generator_bank_if.master bus
`ifdef SPIKE_GEN_OVERFLOW_CNT_EN
    ,
    output logic [15:0] ovf_count
`endif
);

    prog_state_e       state_q, state_d;
    gen_array_t        gens_q, gens_d;
    logic [NGENS-1:0]  pending_q, pending_d;
    logic [NGENS-1:0]  fire;
    logic [NGENS-1:0]  progHit;
    logic              progWrite;
    logic [NIDX-1:0]   rrPtr_q;
    logic [NIDX-1:0]   grant;
    logic              anyPending;
    logic              loadEn;
    logic [NTAG-1:0]   outTag_q;
    logic [NCT-1:0]    outCt_q;
    logic              outV_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PROG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A write only happens from IDLE, so a valid still high during the ack cycle cannot write twice.
    always_comb begin
        state_d   = state_q;
        progWrite = 1'b0;
        case (state_q)
            PROG_IDLE: begin
                if (bus.prog_v) begin
                    progWrite = 1'b1;
                    state_d   = PROG_ACK;
                end
            end
            PROG_ACK: state_d = PROG_IDLE;
            default:  state_d = PROG_IDLE;
        endcase
    end

    assign bus.prog_a = (state_q == PROG_ACK);

    // Programming a generator overrides its tick in the same cycle, so it cannot fire then.
    always_comb begin
        gens_d  = gens_q;
        fire    = '0;
        progHit = '0;
        for (int i = 0; i < NGENS; i++) begin
            if (progWrite && (bus.prog_gen_idx == NIDX'(i))) begin
                progHit[i]       = 1'b1;
                gens_d[i].period = bus.prog_period;
                gens_d[i].cnt    = bus.prog_ticks;
                gens_d[i].tag    = bus.prog_tag;
                gens_d[i].ct     = bus.prog_ct;
            end else if (time_unit && (gens_q[i].period != '0)) begin
                if (gens_q[i].cnt == '0) begin
                    fire[i]       = 1'b1;
                    gens_d[i].cnt = gens_q[i].period - 1'b1;
                end else begin
                    gens_d[i].cnt = gens_q[i].cnt - 1'b1;
                end
            end
        end
    end

    rr_pending_arbiter u_arbiter (
        .pending_i (pending_q),
        .ptr_i     (rrPtr_q),
        .grant_o   (grant),
        .any_o     (anyPending)
    );

    assign loadEn = !outV_q || bus.out_r;

    // A fresh fire beats the clear from a load, so the new spike stays pending.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NGENS; i++) begin
            if (progHit[i]) begin
                pending_d[i] = 1'b0;
            end else if (fire[i]) begin
                pending_d[i] = 1'b1;
            end else if (loadEn && anyPending && (grant == NIDX'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gens_q    <= '0;
            pending_q <= '0;
        end else begin
            gens_q    <= gens_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outTag_q <= '0;
            outCt_q  <= '0;
            outV_q   <= 1'b0;
            rrPtr_q  <= '0;
        end else if (loadEn) begin
            if (anyPending) begin
                outTag_q <= gens_q[grant].tag;
                outCt_q  <= gens_q[grant].ct;
                outV_q   <= 1'b1;
                rrPtr_q  <= nextIdx(grant);
            end else begin
                outV_q <= 1'b0;
            end
        end
    end

    assign bus.out_tag = outTag_q;
    assign bus.out_ct  = outCt_q;
    assign bus.out_v   = outV_q;

`ifdef SPIKE_GEN_OVERFLOW_CNT_EN
    logic [NGENS-1:0] drop;
    logic [16:0]      ovfSum;
    logic [15:0]      ovf_q, ovf_d;

    // A drop is a fire onto a pending bit that is not being emptied by a load this cycle.
    always_comb begin
        drop = '0;
        for (int i = 0; i < NGENS; i++) begin
            drop[i] = fire[i] && pending_q[i] &&
                      !(loadEn && anyPending && (grant == NIDX'(i)));
        end
        ovfSum = {1'b0, ovf_q} + 17'($countones(drop));
        ovf_d  = ovfSum[16] ? 16'hFFFF : ovfSum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`endif

endmodule
